ascon_host_sequencer: RTL

//  Host-side driver and collector for the ASCON controller. Takes one command (mode, AD/message byte

---
 rtl/ascon_host_sequencer_if.sv | 46 ++++
 rtl/ascon_host_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ascon_host_sequencer_if.sv
// rtl/ascon_host_sequencer_if.sv - host command, upstream stream, controller and output signal bundle
interface ascon_host_sequencer_if #(
   parameter int LEN_W = 16
);
   logic             cmd_start;
   logic [1:0]       cmd_mode;
   logic [LEN_W-1:0] cmd_ad_len;
   logic [LEN_W-1:0] cmd_msg_len;
   logic [127:0]     cmd_exp_tag;
   logic [63:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic             ctl_start;
   logic [1:0]       ctl_mode;
   logic [3:0]       ctl_datalen;
   logic [63:0]      ctl_blockin;
   logic             ctl_AD_read;
   logic             ctl_CTv;
   logic             ctl_Tv;
   logic [63:0]      ctl_CTblock;
   logic [127:0]     ctl_Tag;
   logic [2:0]       ctl_state;
   logic [63:0]      out_data;
   logic [3:0]       out_bytes;
   logic             out_valid;
   logic [127:0]     tag_out;
   logic             done;
   logic             auth_ok;
   logic             err_underrun;

   modport master (
      output cmd_start, cmd_mode, cmd_ad_len, cmd_msg_len, cmd_exp_tag,
      output in_data, in_valid,
      output ctl_AD_read, ctl_CTv, ctl_Tv, ctl_CTblock, ctl_Tag, ctl_state,
      input  in_ready, ctl_start, ctl_mode, ctl_datalen, ctl_blockin,
      input  out_data, out_bytes, out_valid, tag_out, done, auth_ok, err_underrun
   );

   modport slave (
      input  cmd_start, cmd_mode, cmd_ad_len, cmd_msg_len, cmd_exp_tag,
      input  in_data, in_valid,
      input  ctl_AD_read, ctl_CTv, ctl_Tv, ctl_CTblock, ctl_Tag, ctl_state,
      output in_ready, ctl_start, ctl_mode, ctl_datalen, ctl_blockin,
      output out_data, out_bytes, out_valid, tag_out, done, auth_ok, err_underrun
   );
endinterface

// File: rtl/ascon_host_sequencer.sv
// rtl/ascon_host_sequencer.sv - feeds AD/message blocks to the ASCON controller, collects output and tag
module ascon_host_sequencer #(
   parameter int LEN_W = 16
) (
   input logic                   i_clk,
   input logic                   i_nRST,
   ascon_host_sequencer_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [1:0]       r_mode;
   logic [LEN_W-1:0] r_msg_len;
   logic [LEN_W-1:0] r_rem;
   logic [127:0]     r_exp_tag;
   logic [127:0]     r_tag;
   logic [63:0]      r_cur;
   logic             r_loaded;
   logic             r_phase_msg;
   logic             r_fin;
   logic             r_ctl_start;
   logic             r_done;
   logic             r_auth_ok;
   logic             r_err;

   logic             w_active;
   logic             w_frozen;
   logic             w_need_word;
   logic [3:0]       w_datalen;
   logic [63:0]      w_mask;
   logic [63:0]      w_out_mask;
   logic             w_cur_valid;
   logic             w_take;
   logic             w_adv;
   logic             w_out_valid;

   assign w_active    = (r_state == S_LOAD) || (r_state == S_RUN);
   assign w_frozen    = (bus.ctl_state == 3'd5);
   assign w_need_word = (r_rem != '0);
   assign w_datalen   = (r_rem >= LEN_W'(8)) ? 4'd8 : {1'b0, r_rem[2:0]};
   // Keep the leading datalen bytes (byte0 sits in the MSBs)
   assign w_mask      = ~(64'hFFFF_FFFF_FFFF_FFFF >> {w_datalen, 3'b000});
   // A pad-only block (rem==0) is valid without consuming an upstream word
   assign w_cur_valid = w_active && !r_fin && (r_loaded || !w_need_word);
   assign w_take      = (r_state == S_RUN) && !w_frozen && !r_fin &&
                        (bus.ctl_AD_read || bus.ctl_CTv);
   assign w_adv       = w_take && w_cur_valid;
   assign w_out_valid = w_adv && bus.ctl_CTv && r_phase_msg && (w_datalen != 4'd0);
   assign w_out_mask  = w_out_valid ? w_mask : 64'd0;

   assign bus.in_ready     = w_active && !w_frozen && !r_fin && !r_loaded && w_need_word;
   assign bus.ctl_start    = r_ctl_start;
   assign bus.ctl_mode     = r_mode;
   assign bus.ctl_datalen  = w_datalen;
   assign bus.ctl_blockin  = r_cur & w_mask;
   assign bus.out_valid    = w_out_valid;
   assign bus.out_bytes    = w_out_valid ? w_datalen : 4'd0;
   assign bus.out_data     = bus.ctl_CTblock & w_out_mask;
   assign bus.tag_out      = r_tag;
   assign bus.done         = r_done;
   assign bus.auth_ok      = r_auth_ok;
   assign bus.err_underrun = r_err;

   always_ff @(posedge i_clk or negedge i_nRST) begin
      if (!i_nRST) begin
         r_state     <= S_IDLE;
         r_mode      <= '0;
         r_msg_len   <= '0;
         r_rem       <= '0;
         r_exp_tag   <= '0;
         r_tag       <= '0;
         r_cur       <= '0;
         r_loaded    <= 1'b0;
         r_phase_msg <= 1'b0;
         r_fin       <= 1'b0;
         r_ctl_start <= 1'b0;
         r_done      <= 1'b0;
         r_auth_ok   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ctl_start <= 1'b0;
         r_done      <= 1'b0;

         if (bus.in_valid && bus.in_ready) begin
            r_cur    <= bus.in_data;
            r_loaded <= 1'b1;
         end

         if (w_adv) begin
            r_loaded <= 1'b0;
            r_cur    <= '0;
            if (w_datalen == 4'd8) begin
               r_rem <= r_rem - LEN_W'(8);
            end else if (!r_phase_msg) begin
               r_phase_msg <= 1'b1;
               r_rem       <= r_msg_len;
            end else begin
               r_fin <= 1'b1;
            end
         end

         if (w_take && !w_cur_valid) begin
            r_err <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.cmd_start) begin
                  r_state     <= S_LOAD;
                  r_mode      <= bus.cmd_mode;
                  r_msg_len   <= bus.cmd_msg_len;
                  r_exp_tag   <= bus.cmd_exp_tag;
                  r_rem       <= bus.cmd_mode[1] ? bus.cmd_ad_len : bus.cmd_msg_len;
                  r_phase_msg <= !bus.cmd_mode[1];
                  r_fin       <= 1'b0;
                  r_loaded    <= 1'b0;
                  r_cur       <= '0;
                  r_err       <= 1'b0;
                  r_auth_ok   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_cur_valid) begin
                  r_state     <= S_RUN;
                  r_ctl_start <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.ctl_Tv) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_tag     <= bus.ctl_Tag;
                  r_auth_ok <= r_mode[0] || (bus.ctl_Tag == r_exp_tag);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
